// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, execute-side control and the decoded IF/ID fields.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned INSN_WIDTH = 28
);
    logic [ADDR_WIDTH-1:0] oAddress;
    logic [INSN_WIDTH-1:0] iInstruction;
    logic                  iStall;
    logic                  iRedirect;
    logic [ADDR_WIDTH-1:0] iRedirectAddr;
    logic                  oValid;
    logic [ADDR_WIDTH-1:0] oPC;
    logic [3:0]            oOperation;
    logic [7:0]            oDestination;
    logic [7:0]            oSource1;
    logic [7:0]            oSource0;
    logic [15:0]           oImmediate;
    logic                  oBusy;

    // Fetch unit side
    modport master (
        output oAddress, oValid, oPC, oOperation, oDestination,
               oSource1, oSource0, oImmediate, oBusy,
        input  iInstruction, iStall, iRedirect, iRedirectAddr
    );

    // ROM / execute-stage side
    modport slave (
        input  oAddress, oValid, oPC, oOperation, oDestination,
               oSource1, oSource0, oImmediate, oBusy,
        output iInstruction, iStall, iRedirect, iRedirectAddr
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the combinational ROM address,
// captures the returned word into IF/ID and exposes its fields as registered slices.
// Optional feature macro: FETCH_NOP_DELAY_EN (NOP with nonzero payload inserts N bubbles).
module instruction_fetch_unit #(
    parameter int unsigned          ADDR_WIDTH = 16,
    parameter int unsigned          INSN_WIDTH = 28,
    parameter logic [3:0]           NOP_OPCODE = 4'd0,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic iClock,
    input  logic iReset_n,
    instruction_fetch_if.master bus
);

    localparam int unsigned DELAY_WIDTH = INSN_WIDTH - 4;

    logic [ADDR_WIDTH-1:0] pc_q,    pc_d;
    logic [INSN_WIDTH-1:0] ifid_q,  ifid_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] fpc_q,   fpc_d;

`ifdef FETCH_NOP_DELAY_EN
    logic [DELAY_WIDTH-1:0] cnt_q,  cnt_d;
    logic                   busy_q, busy_d;
`endif

    // Next-state selection: redirect > stall > delay countdown > normal fetch
    always_comb begin
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        valid_d = valid_q;
        fpc_d   = fpc_q;
`ifdef FETCH_NOP_DELAY_EN
        cnt_d   = cnt_q;
        busy_d  = busy_q;
`endif
        if (bus.iRedirect) begin
            pc_d    = bus.iRedirectAddr;
            ifid_d  = '0;
            valid_d = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            cnt_d   = '0;
            busy_d  = 1'b0;
`endif
        end else if (bus.iStall) begin
            // everything holds, including the delay counter
            pc_d = pc_q;
`ifdef FETCH_NOP_DELAY_EN
        end else if (cnt_q != '0) begin
            // bubble: PC holds, IF/ID marked empty
            valid_d = 1'b0;
            cnt_d   = cnt_q - DELAY_WIDTH'(1);
            busy_d  = (cnt_q != DELAY_WIDTH'(1));
`endif
        end else begin
            ifid_d  = bus.iInstruction;
            fpc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(1);
`ifdef FETCH_NOP_DELAY_EN
            if ((bus.iInstruction[INSN_WIDTH-1 -: 4] == NOP_OPCODE) &&
                (bus.iInstruction[DELAY_WIDTH-1:0] != '0)) begin
                cnt_d  = bus.iInstruction[DELAY_WIDTH-1:0];
                busy_d = 1'b1;
            end
`endif
        end
    end

    // Fetch state registers
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
            valid_q <= 1'b0;
            fpc_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            valid_q <= valid_d;
            fpc_q   <= fpc_d;
        end
    end

`ifdef FETCH_NOP_DELAY_EN
    // NOP-delay counter and its registered busy flag
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign bus.oBusy = busy_q;
`else
    assign bus.oBusy = 1'b0;
`endif

    // Outputs are straight taps of the registers
    assign bus.oAddress     = pc_q;
    assign bus.oValid       = valid_q;
    assign bus.oPC          = fpc_q;
    assign bus.oOperation   = ifid_q[27:24];
    assign bus.oDestination = ifid_q[23:16];
    assign bus.oSource1     = ifid_q[15:8];
    assign bus.oSource0     = ifid_q[7:0];
    assign bus.oImmediate   = ifid_q[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random
// redirect/stall/reset traffic against a cycle-level behavioural model.
module tb_instruction_fetch_unit;

`ifdef FETCH_NOP_DELAY_EN
    localparam bit DELAY_EN = 1'b1;
`else
    localparam bit DELAY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch_unit dut (
        .iClock   (clk),
        .iReset_n (rst_n),
        .bus      (bus)
    );

    logic [27:0] rom [0:65535];
    assign bus.iInstruction = rom[bus.oAddress];

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_fpc;
    logic [27:0] m_word;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_valid = 1'b0; m_fpc = 16'h0000; m_word = 28'h0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit redir, input logic [15:0] tgt, input bit stall);
        if (redir) begin
            m_pc = tgt; m_word = 28'h0; m_valid = 1'b0; m_cnt = 0;
        end else if (stall) begin
            m_cnt = m_cnt;
        end else if (DELAY_EN && m_cnt > 0) begin
            m_valid = 1'b0; m_cnt = m_cnt - 1;
        end else begin
            m_word  = rom[m_pc];
            m_fpc   = m_pc;
            m_valid = 1'b1;
            m_pc    = 16'((int'(m_pc) + 1) % 65536);
            if (DELAY_EN && m_word[27:24] == 4'd0 && m_word[23:0] != 24'd0)
                m_cnt = int'(m_word[23:0]);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".addr"},  32'(bus.oAddress), 32'(m_pc));
        check({tag, ".valid"}, 32'(bus.oValid),   32'(m_valid));
        check({tag, ".busy"},  32'(bus.oBusy),    32'(m_cnt != 0));
        if (m_valid) begin
            check({tag, ".pc"},  32'(bus.oPC),          32'(m_fpc));
            check({tag, ".op"},  32'(bus.oOperation),   32'(m_word[27:24]));
            check({tag, ".dst"}, 32'(bus.oDestination), 32'(m_word[23:16]));
            check({tag, ".s1"},  32'(bus.oSource1),     32'(m_word[15:8]));
            check({tag, ".s0"},  32'(bus.oSource0),     32'(m_word[7:0]));
            check({tag, ".imm"}, 32'(bus.oImmediate),   32'(m_word[15:0]));
        end
    endtask

    task automatic step(input string tag, input bit redir, input logic [15:0] tgt, input bit stall);
        bus.iRedirect     = redir;
        bus.iRedirectAddr = tgt;
        bus.iStall        = stall;
        @(posedge clk);
        model_edge(redir, tgt, stall);
        #1;
        compare_all(tag);
    endtask

    // asynchronous reset in mid-cycle, held across one edge, released away from the edge
    task automatic do_reset(input string tag);
        bus.iRedirect = 1'b0; bus.iStall = 1'b0; bus.iRedirectAddr = 16'h0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".rst_addr"},  32'(bus.oAddress), 32'h0);
        check({tag, ".rst_valid"}, 32'(bus.oValid),   32'h0);
        check({tag, ".rst_busy"},  32'(bus.oBusy),    32'h0);
        check({tag, ".rst_pc"},    32'(bus.oPC),      32'h0);
        @(posedge clk);
        #1;
        compare_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        bus.iRedirect = 1'b0; bus.iStall = 1'b0; bus.iRedirectAddr = 16'h0;
        for (int i = 0; i < 65536; i++) begin
            logic [27:0] w;
            w = 28'($urandom);
            if (w[27:24] == 4'd0) w[23:0] = 24'($urandom_range(0, 5));
            rom[i] = w;
        end
        // low addresses and the top word are never NOPs, except the delay NOP at 0
        for (int i = 1; i < 16; i++) if (rom[i][27:24] == 4'd0) rom[i][27:24] = 4'd1;
        if (rom[65535][27:24] == 4'd0) rom[65535][27:24] = 4'd1;
        rom[0] = {4'd0, 24'd4};
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        compare_all("por");
        rst_n = 1'b1;

        // sequential fetch from reset, including the delay NOP at address 0
        for (int i = 0; i < 8; i++) step("seq", 1'b0, 16'h0, 1'b0);

        // mid-run reset
        do_reset("midrst");
        for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 16'h0, 1'b0);

        // stall hold at PC=5
        step("to5", 1'b1, 16'h0005, 1'b0);
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 16'h0, 1'b1);
        step("unstall", 1'b0, 16'h0, 1'b0);
        check("unstall.pc5", 32'(bus.oPC), 32'h5);
        check("unstall.addr6", 32'(bus.oAddress), 32'h6);

        // redirect wins over stall
        step("redir_stall", 1'b1, 16'h0002, 1'b1);
        check("redir_stall.bubble", 32'(bus.oValid), 32'h0);
        step("redir_tgt", 1'b0, 16'h0, 1'b0);
        check("redir_tgt.pc2", 32'(bus.oPC), 32'h2);

        // PC wrap at the top of the address space
        step("wrap0", 1'b1, 16'hFFFF, 1'b0);
        step("wrap1", 1'b0, 16'h0, 1'b0);
        check("wrap.addr0", 32'(bus.oAddress), 32'h0);
        check("wrap.pcffff", 32'(bus.oPC), 32'hFFFF);

        // redirect and reset while a delay may be counting down
        step("d_redir0", 1'b1, 16'h0000, 1'b0);
        step("d_cap", 1'b0, 16'h0, 1'b0);
        step("d_hold", 1'b0, 16'h0, 1'b0);
        step("d_kill", 1'b1, 16'h0008, 1'b0);
        step("d_resume", 1'b0, 16'h0, 1'b0);
        step("d_redir1", 1'b1, 16'h0000, 1'b0);
        step("d_cap2", 1'b0, 16'h0, 1'b0);
        do_reset("d_rst");
        step("d_rst_fetch", 1'b0, 16'h0, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit          redir;
            bit          stall;
            logic [15:0] tgt;
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else begin
                redir = ($urandom_range(0, 9) == 0);
                tgt   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7)))
                                                     : 16'($urandom);
                stall = (m_cnt == 0) && ($urandom_range(0, 4) == 0);
                step("rnd", redir, tgt, stall);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
